display_scan_ctrl: RTL and testbench

//  Time-multiplexed scan driver for the 4-digit 7-segment clock display.

---
 rtl/display_pkg.sv | 16 +
 rtl/display_scan_ctrl_tick_gen.sv | 26 ++
 rtl/display_scan_ctrl.sv | 121 ++++++++++++
 tb/tb_display_scan_ctrl.sv | 135 +++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants and helpers for the 4-digit 7-segment scan driver.
package display_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 4'b1111;

    typedef enum logic {
        PHASE_ON    = 1'b0,
        PHASE_BLANK = 1'b1
    } blink_phase_e;

    function automatic logic [NUM_DIGITS-1:0] anode_onehot_n(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/display_scan_ctrl_tick_gen.sv
// Free-running prescaler: o_tick is high for one cycle every DIV cycles.
module tick_gen #(
    parameter int unsigned DIV = 100000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_tick
);

    localparam int unsigned CW = $clog2(DIV);

    logic [CW-1:0] r_cnt;

    assign o_tick = (r_cnt == CW'(DIV - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Scan driver for a 4-digit 7-segment display with a per-slot blank guard window.
// Optional digit blinking is enabled by defining DISP_BLINK_EN.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned GUARD        = 1000,
    parameter int unsigned BLINK_FRAMES = 125
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] digit_en,
`ifdef DISP_BLINK_EN
    input  logic [3:0] blink_mask,
`endif
    output logic       S0,
    output logic       S1,
    output logic [3:0] an,
    output logic       slot_tick,
    output logic       frame_start
);

    localparam int unsigned GW = (GUARD > 0) ? $clog2(GUARD + 1) : 1;

    if (REFRESH_DIV < 2 || GUARD >= REFRESH_DIV || BLINK_FRAMES < 1) begin : g_bad_param
        $error("display_scan_ctrl: illegal REFRESH_DIV/GUARD/BLINK_FRAMES combination");
    end

    logic          w_tick;
    logic          w_wrap;
    logic [1:0]    w_idx_next;
    logic [GW-1:0] w_guard_next;
    logic [3:0]    w_blink_n;
    logic [3:0]    w_an_next;

    logic [1:0]    r_idx;
    logic [GW-1:0] r_guard;
    logic [3:0]    r_an;
    logic          r_slot_tick;
    logic          r_frame_start;

    tick_gen #(.DIV(REFRESH_DIV)) u_tick_gen (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .o_tick  (w_tick)
    );

    assign w_wrap = w_tick && (r_idx == 2'd3);

    // Anodes are computed from next-state values so they switch on the same edge as the select.
    always_comb begin
        w_idx_next = w_tick ? r_idx + 2'd1 : r_idx;
        if (w_tick) begin
            w_guard_next = GW'(GUARD);
        end else if (r_guard != '0) begin
            w_guard_next = r_guard - GW'(1);
        end else begin
            w_guard_next = '0;
        end
        if (w_guard_next != '0) begin
            w_an_next = ANODE_OFF;
        end else begin
            w_an_next = anode_onehot_n(w_idx_next) | ~digit_en | w_blink_n;
        end
    end

`ifdef DISP_BLINK_EN
    localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [FW-1:0] r_frame_cnt;
    blink_phase_e  r_phase;
    blink_phase_e  w_phase_next;
    logic          w_frame_last;

    assign w_frame_last = (r_frame_cnt == FW'(BLINK_FRAMES - 1));

    always_comb begin
        w_phase_next = r_phase;
        if (w_wrap && w_frame_last) begin
            w_phase_next = (r_phase == PHASE_ON) ? PHASE_BLANK : PHASE_ON;
        end
        w_blink_n = (w_phase_next == PHASE_BLANK) ? blink_mask : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
            r_phase     <= PHASE_ON;
        end else begin
            r_phase <= w_phase_next;
            if (w_wrap) begin
                r_frame_cnt <= w_frame_last ? '0 : r_frame_cnt + FW'(1);
            end
        end
    end
`else
    assign w_blink_n = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx         <= '0;
            r_guard       <= GW'(GUARD);
            r_an          <= ANODE_OFF;
            r_slot_tick   <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_idx         <= w_idx_next;
            r_guard       <= w_guard_next;
            r_an          <= w_an_next;
            r_slot_tick   <= w_tick;
            r_frame_start <= w_wrap;
        end
    end

    assign {S1, S0}    = r_idx;
    assign an          = r_an;
    assign slot_tick   = r_slot_tick;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl: GUARD=2 and GUARD=0 instances run side by side.
module tb_display_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] digit_en = 4'b1111;
    logic [3:0] blink_mask = 4'b0001;

    logic       s0_a, s1_a, st_a, fs_a;
    logic [3:0] an_a;
    logic       s0_b, s1_b, st_b, fs_b;
    logic [3:0] an_b;

    int vectors = 0;
    int errors  = 0;

`ifdef DISP_BLINK_EN
    localparam logic [3:0] BMASK = 4'b0001;
`else
    localparam logic [3:0] BMASK = 4'b0000;
`endif

    display_scan_ctrl #(.REFRESH_DIV(8), .GUARD(2), .BLINK_FRAMES(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .digit_en    (digit_en),
`ifdef DISP_BLINK_EN
        .blink_mask  (blink_mask),
`endif
        .S0          (s0_a),
        .S1          (s1_a),
        .an          (an_a),
        .slot_tick   (st_a),
        .frame_start (fs_a)
    );

    display_scan_ctrl #(.REFRESH_DIV(8), .GUARD(0), .BLINK_FRAMES(2)) dut0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .digit_en    (digit_en),
`ifdef DISP_BLINK_EN
        .blink_mask  (blink_mask),
`endif
        .S0          (s0_b),
        .S1          (s1_b),
        .an          (an_b),
        .slot_tick   (st_b),
        .frame_start (fs_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " an"},      an_a, 4'b1111);
        chk({tag, " sel"},     {2'b00, s1_a, s0_a}, 4'd0);
        chk({tag, " pulses"},  {2'b00, st_a, fs_a}, 4'd0);
        chk({tag, " an0"},     an_b, 4'b1111);
        chk({tag, " sel0"},    {2'b00, s1_b, s0_b}, 4'd0);
        chk({tag, " pulses0"}, {2'b00, st_b, fs_b}, 4'd0);
    endtask

    // Lit pattern for a digit: its own anode low unless disabled or blanked by blink.
    function automatic logic [3:0] lit(input int unsigned idx, input logic [3:0] en, input bit phase);
        logic [3:0] one;
        one = 4'b0001 << idx;
        return ~one | ~en | (phase ? BMASK : 4'b0000);
    endfunction

    // Runs n cycles from reset release, cycle 0 being the current one.
    task automatic run_scan(input int unsigned n, input bit vary_en);
        logic [3:0] en_seen;
        logic [3:0] exp_a, exp_b;
        int unsigned s, k, idx;
        bit phase;
        for (int unsigned c = 0; c < n; c++) begin
            en_seen = digit_en;
            if (c > 0) step();
            s = c / 8;
            k = c % 8;
            idx = s % 4;
            phase = ((s / 4) / 2) % 2 == 1;
            exp_b = (c == 0) ? 4'b1111 : lit(idx, en_seen, phase);
            exp_a = (k < 2) ? 4'b1111 : lit(idx, en_seen, phase);
            chk($sformatf("c%0d sel", c),   {2'b00, s1_a, s0_a}, 4'(idx));
            chk($sformatf("c%0d an", c),    an_a, exp_a);
            chk($sformatf("c%0d tick", c),  {3'b000, st_a}, {3'b000, (k == 0 && s > 0)});
            chk($sformatf("c%0d frame", c), {3'b000, fs_a}, {3'b000, (k == 0 && s > 0 && idx == 0)});
            chk($sformatf("c%0d sel0", c),  {2'b00, s1_b, s0_b}, 4'(idx));
            chk($sformatf("c%0d an0", c),   an_b, exp_b);
            if (vary_en) begin
                if (s == 3 && k == 7) digit_en = 4'b1011;
                if (s == 7 && k == 7) digit_en = 4'b1111;
                if (s == 9 && k == 3) digit_en = 4'b1101;
                if (s == 9 && k == 7) digit_en = 4'b1111;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        digit_en = 4'b1111;
        repeat (3) step();
        chk_reset_vals("reset");

        rst_n = 1'b1;
        run_scan(18 * 8 + 6, 1'b1);

        // Now at cycle 5 of an idx-2 slot: async reset must act without a clock edge.
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midreset");
        repeat (2) step();
        chk_reset_vals("midreset_hold");

        rst_n = 1'b1;
        run_scan(2 * 8 + 2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
